led_pattern_sequencer: RTL

- Controller that schedules the 10-LED bank (LEDR) driven from the board switches (SW).
- In EDIT mode, LEDR[7:0] mirrors SW[7:0] live. Pressing KEY1 captures SW[7:0] into a small pattern buffer.
- In RUN mode, the stored patterns play back round-robin on LEDR[7:0], each held for a programmable dwell time.
- LEDR[9:8] report controller status. The block sits between the board I/O and the LED bank.

---
 rtl/led_pattern_sequencer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: drives the 10-LED bank from the board switches.
// In EDIT, LEDR[7:0] mirrors SW[7:0], and a KEY1 press stores SW[7:0] in a small pattern buffer.
// In RUN, the stored patterns replay round-robin, each shown for DWELL_CYCLES clocks.
//
// Ports:
//   CLOCK_50  system clock, all logic on the rising edge
//   KEY0      synchronous active-low reset
//   KEY1      active-low load pushbutton, asynchronous to CLOCK_50
//   SW[7:0]   pattern data; SW[8] run enable; SW[9] clear buffer (level)
//   LEDR[7:0] displayed pattern; LEDR[8] buffer full; LEDR[9] running
//   count     number of valid buffer entries (0..DEPTH)
module led_pattern_sequencer #(
    parameter int unsigned DWELL_CYCLES = 25000000,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned CW           = 3
) (
    input  logic          CLOCK_50,
    input  logic          KEY0,
    input  logic          KEY1,
    input  logic [9:0]    SW,
    output logic [9:0]    LEDR,
    output logic [CW-1:0] count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    typedef enum logic {
        EDIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state, state_n;
    logic            key_s1, key_s2, key_d;
    logic            load_c;
    logic            we_c;
    logic [AW-1:0]   wr_ptr, wr_ptr_n;
    logic [AW-1:0]   rd_idx, rd_idx_n;
    logic [CW-1:0]   count_n;
    logic [DW-1:0]   dwell, dwell_n;
    logic [9:0]      ledr_n;
    logic            full_c;
    logic [7:0]      pat_mem [DEPTH];

    // KEY1 synchronizer plus a delayed copy for falling-edge detection.
    always_ff @(posedge CLOCK_50) begin
        if (!KEY0) begin
            key_s1 <= 1'b1;
            key_s2 <= 1'b1;
            key_d  <= 1'b1;
        end else begin
            key_s1 <= KEY1;
            key_s2 <= key_s1;
            key_d  <= key_s2;
        end
    end

    // One-cycle load pulse on each press, independent of hold time.
    assign load_c = key_d & ~key_s2;
    assign full_c = (count == CW'(DEPTH));

    // State register and registered datapath.
    always_ff @(posedge CLOCK_50) begin
        if (!KEY0) begin
            state  <= EDIT;
            count  <= '0;
            wr_ptr <= '0;
            rd_idx <= '0;
            dwell  <= '0;
            LEDR   <= '0;
        end else begin
            state  <= state_n;
            count  <= count_n;
            wr_ptr <= wr_ptr_n;
            rd_idx <= rd_idx_n;
            dwell  <= dwell_n;
            LEDR   <= ledr_n;
        end
    end

    // Pattern buffer; contents are not reset.
    always_ff @(posedge CLOCK_50) begin
        if (KEY0 && we_c) begin
            pat_mem[wr_ptr] <= SW[7:0];
        end
    end

    // Next-state, counters and display selection.
    always_comb begin
        state_n  = state;
        count_n  = count;
        wr_ptr_n = wr_ptr;
        rd_idx_n = rd_idx;
        dwell_n  = dwell;
        we_c     = 1'b0;
        // Status bits follow the same current-state alignment as the pattern bits.
        ledr_n   = {(state == RUN), full_c, SW[7:0]};
        if (state == RUN) begin
            ledr_n[7:0] = pat_mem[rd_idx];
        end

        if (SW[9]) begin
            // Clear wins over load and run enable.
            state_n  = EDIT;
            count_n  = '0;
            wr_ptr_n = '0;
            rd_idx_n = '0;
            dwell_n  = '0;
        end else begin
            case (state)
                EDIT: begin
                    if (load_c && !full_c) begin
                        we_c     = 1'b1;
                        wr_ptr_n = wr_ptr + AW'(1);
                        count_n  = count + CW'(1);
                    end
                    if (SW[8] && (count != '0)) begin
                        state_n  = RUN;
                        rd_idx_n = '0;
                        dwell_n  = '0;
                    end
                end
                RUN: begin
                    if (!SW[8]) begin
                        state_n = EDIT;
                    end else if (dwell == DW'(DWELL_CYCLES - 1)) begin
                        dwell_n = '0;
                        // Wrap at the number of stored entries, not at DEPTH.
                        if (rd_idx == AW'(count - CW'(1))) begin
                            rd_idx_n = '0;
                        end else begin
                            rd_idx_n = rd_idx + AW'(1);
                        end
                    end else begin
                        dwell_n = dwell + DW'(1);
                    end
                end
                default: state_n = EDIT;
            endcase
        end
    end

endmodule
